fpmul_rr_arbiter: RTL and testbench

//  Shares one multiplier32FP instance between N_REQ requesters. Round-robin arbitration,

---
 rtl/fpmul_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fpmul_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_rr_arbiter.sv
// fpmul_rr_arbiter
//   Shares a single multiplier32FP core between N_REQ requesters. A round-robin
//   pick is accepted in IDLE. The operands are registered toward the multiplier,
//   and a one-cycle start pulse is issued. The block then waits for done, with a
//   watchdog. The product and flags are returned to the granted requester over a
//   valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o    per-requester request handshake (ready is one-hot)
//   req_a_i/req_b_i            packed operands, slice i = [32*i +: 32]
//   rsp_valid_o/rsp_ready_i    per-requester response handshake (valid is one-hot)
//   rsp_product_o/rsp_flags_o  result word and {nan, inf, overflow, underflow}
//   rsp_timeout_o              response was produced by the watchdog
//   grant_id_o                 index of the current/last grant
//   busy_o                     operation in flight (not IDLE)
//   mul_*                      interface to the multiplier core
module fpmul_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*32-1:0]      req_a_i,
    input  logic [N_REQ*32-1:0]      req_b_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic [31:0]              rsp_product_o,
    output logic [3:0]               rsp_flags_o,
    output logic                     rsp_timeout_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     busy_o,
    output logic [31:0]              mul_a_o,
    output logic [31:0]              mul_b_o,
    output logic                     mul_start_o,
    input  logic                     mul_done_i,
    input  logic [31:0]              mul_product_i,
    input  logic                     mul_nan_i,
    input  logic                     mul_inf_i,
    input  logic                     mul_ovf_i,
    input  logic                     mul_unf_i
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [31:0] TIMEOUT_PRODUCT = 32'h7FC0_0000;  // quiet NaN
    localparam logic [3:0]  TIMEOUT_FLAGS   = 4'b1000;        // nan only

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic [CW-1:0]   wd_cnt;
    logic            any_valid;
    logic            wd_expired;
    logic            rsp_accept;

    // Nearest valid requester after last_grant, wrapping modulo N_REQ. The loop
    // runs from the farthest offset down so the nearest one is written last.
    function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [GW-1:0]    last);
        logic [GW-1:0] p;
        int            idx;
        p = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(last) + off) % N_REQ;
            if (valid[idx]) p = GW'(idx);
        end
        return p;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign any_valid  = |req_valid_i;
    assign pick       = rr_pick(req_valid_i, last_grant);
    assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));
    assign rsp_accept = rsp_ready_i[grant_id_o];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        rsp_valid_o = '0;
        mul_start_o = 1'b0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready_o = onehot(pick);
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_o = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (mul_done_i || wd_expired) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_o = onehot(grant_id_o);
                if (rsp_accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= GW'(N_REQ - 1);
            grant_id_o    <= '0;
            mul_a_o       <= '0;
            mul_b_o       <= '0;
            rsp_product_o <= '0;
            rsp_flags_o   <= '0;
            rsp_timeout_o <= 1'b0;
            wd_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        mul_a_o    <= req_a_i[pick*32 +: 32];
                        mul_b_o    <= req_b_i[pick*32 +: 32];
                        grant_id_o <= pick;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    // done has priority over a watchdog expiring in the same cycle
                    if (mul_done_i) begin
                        rsp_product_o <= mul_product_i;
                        rsp_flags_o   <= {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
                        rsp_timeout_o <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_product_o <= TIMEOUT_PRODUCT;
                        rsp_flags_o   <= TIMEOUT_FLAGS;
                        rsp_timeout_o <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_accept) last_grant <= grant_id_o;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
module tb_fpmul_rr_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*32-1:0] req_a_i, req_b_i;
    logic [N-1:0]   rsp_valid_o;
    logic [N-1:0]   rsp_ready_i;
    logic [31:0]    rsp_product_o;
    logic [3:0]     rsp_flags_o;
    logic           rsp_timeout_o;
    logic [1:0]     grant_id_o;
    logic           busy_o;
    logic [31:0]    mul_a_o, mul_b_o;
    logic           mul_start_o;
    logic           mul_done_i;
    logic [31:0]    mul_product_i;
    logic           mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i;

    fpmul_rr_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_product_o(rsp_product_o), .rsp_flags_o(rsp_flags_o),
        .rsp_timeout_o(rsp_timeout_o), .grant_id_o(grant_id_o), .busy_o(busy_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_start_o(mul_start_o),
        .mul_done_i(mul_done_i), .mul_product_i(mul_product_i),
        .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i),
        .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Multiplier stand-in: done arrives mdelay cycles after start is seen;
    // mdelay == 0 means it never answers.
    int          mdelay = 1;
    logic [31:0] mprod_v = '0;
    logic [3:0]  mflags_v = '0;
    logic        stray_done = 1'b0;
    int          cd = 0;

    initial begin
        mul_done_i = 1'b0;
        mul_product_i = '0;
        {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = 4'b0;
        forever begin
            @(posedge clk); #1;
            mul_done_i = 1'b0;
            if (!rst_n) cd = 0;
            else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) mul_done_i = 1'b1;
                end
                if (mul_start_o && mdelay > 0) cd = mdelay;
            end
            if (stray_done) mul_done_i = 1'b1;
            mul_product_i = mprod_v;
            {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = mflags_v;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Round-robin rule: the valid requester whose distance after last is smallest.
    function automatic int rr_ref(input logic [N-1:0] v, input int last);
        int best, bd, d;
        best = -1;
        bd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - last - 1 + 2 * N) % N;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mul_a"}, mul_a_o, 32'h0);
        chk({nm, "_mul_b"}, mul_b_o, 32'h0);
        chk({nm, "_product"}, rsp_product_o, 32'h0);
        chk({nm, "_ctrl"}, {18'h0, rsp_valid_o, req_ready_o, mul_start_o, busy_o,
                            rsp_timeout_o, rsp_flags_o, grant_id_o}, 32'h0);
    endtask

    // Full transaction: request, issue, wait, response with rdly cycles of backpressure.
    task automatic run_op(input string nm, input logic [N-1:0] vmask,
                          input logic [N*32-1:0] a_all, input logic [N*32-1:0] b_all,
                          input int dly, input logic [31:0] mprod, input logic [3:0] mfl,
                          input int rdly, input int exp_g, input logic [31:0] exp_p,
                          input logic [3:0] exp_f, input logic exp_to);
        int          n, starts, exp_lat;
        logic        ok;
        logic [31:0] p0;
        mdelay = dly;
        mprod_v = mprod;
        mflags_v = mfl;
        req_a_i = a_all;
        req_b_i = b_all;
        req_valid_i = vmask;
        #1;
        chk({nm, "_req_ready"}, 32'(req_ready_o), 32'(oh(exp_g)));
        @(posedge clk); #1;
        req_valid_i = '0;
        chk({nm, "_grant"}, 32'(grant_id_o), 32'(exp_g));
        chk({nm, "_mul_a"}, mul_a_o, a_all[exp_g*32 +: 32]);
        chk({nm, "_mul_b"}, mul_b_o, b_all[exp_g*32 +: 32]);
        n = 1;
        starts = mul_start_o ? 1 : 0;
        while (rsp_valid_o == '0 && n < TIMEOUT + 10) begin
            @(posedge clk); #1;
            n++;
            if (mul_start_o) starts++;
        end
        exp_lat = exp_to ? TIMEOUT + 2 : dly + 2;
        chk({nm, "_start_pulses"}, 32'(starts), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_rsp_valid"}, 32'(rsp_valid_o), 32'(oh(exp_g)));
        chk({nm, "_product"}, rsp_product_o, exp_p);
        chk({nm, "_flags"}, 32'(rsp_flags_o), 32'(exp_f));
        chk({nm, "_timeout"}, 32'(rsp_timeout_o), 32'(exp_to));
        // other requesters' ready and fresh requests must both be ignored while held
        ok = 1'b1;
        p0 = rsp_product_o;
        rsp_ready_i = ~oh(exp_g);
        req_valid_i = '1;
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== oh(exp_g) || rsp_product_o !== p0 || rsp_flags_o !== exp_f ||
                req_ready_o !== '0 || mul_start_o !== 1'b0)
                ok = 1'b0;
        end
        if (rdly > 0) chk({nm, "_hold"}, 32'(ok), 32'd1);
        req_valid_i = '0;
        rsp_ready_i = oh(exp_g);
        @(posedge clk); #1;
        rsp_ready_i = '0;
        chk({nm, "_idle_after"}, {30'h0, busy_o, |rsp_valid_o}, 32'h0);
    endtask

    typedef struct {
        logic [N-1:0]   vmask;
        logic [N*32-1:0] a_all;
        logic [N*32-1:0] b_all;
        int             dly;
        logic [31:0]    mprod;
        logic [3:0]     mfl;
        int             rdly;
        int             exp_g;
        logic [31:0]    exp_p;
        logic [3:0]     exp_f;
        logic           exp_to;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int          last, g, dly;
        logic [N-1:0] vm;
        logic [N*32-1:0] aa, bb;
        logic [31:0] mp, ep;
        logic [3:0]  mf, ef;

        // rows 0-7: all requesters valid, grants rotate 0..3 twice
        for (int i = 0; i < 8; i++) begin
            tbl[i].vmask = 4'b1111;
            for (int j = 0; j < N; j++) begin
                tbl[i].a_all[j*32 +: 32] = 32'h4000_0000 + 32'(j << 8) + 32'(i);
                tbl[i].b_all[j*32 +: 32] = 32'hC000_0000 + 32'(j << 12) + 32'(i);
            end
            tbl[i].dly = 1 + i % 3;
            tbl[i].mprod = 32'h1111_0000 + 32'(i);
            tbl[i].mfl = 4'b0000;
            tbl[i].rdly = 0;
            tbl[i].exp_g = i % 4;
            tbl[i].exp_p = 32'h1111_0000 + 32'(i);
            tbl[i].exp_f = 4'b0000;
            tbl[i].exp_to = 1'b0;
        end
        // row 8: requester 2 only, 1.0 * 2.0 = 2.0
        tbl[8] = '{4'b0100, {32'h0, 32'h3F80_0000, 64'h0}, {32'h0, 32'h4000_0000, 64'h0},
                   5, 32'h4000_0000, 4'b0000, 0, 2, 32'h4000_0000, 4'b0000, 1'b0};
        // row 9: backpressure 10 cycles; after grant 2, requester 0 wins over 1
        tbl[9] = '{4'b0011, {64'h0, 32'h4040_0000, 32'h3F00_0000},
                   {64'h0, 32'h4080_0000, 32'h3E80_0000},
                   2, 32'h1234_5678, 4'b0001, 10, 0, 32'h1234_5678, 4'b0001, 1'b0};
        // row 10: infinity with overflow
        tbl[10] = '{4'b1010, {32'h7F00_0000, 32'h0, 32'h7F00_0001, 32'h0},
                    {32'h7F00_0000, 32'h0, 32'h7F00_0002, 32'h0},
                    3, 32'h7F80_0000, 4'b0110, 0, 1, 32'h7F80_0000, 4'b0110, 1'b0};
        // row 11: multiplier never answers -> watchdog response
        tbl[11] = '{4'b1000, {32'h4120_0000, 96'h0}, {32'h4130_0000, 96'h0},
                    0, 32'hDEAD_BEEF, 4'b0111, 0, 3, 32'h7FC0_0000, 4'b1000, 1'b1};
        // row 12: normal operation after a timeout; after 3, requester 1 wins over 2
        tbl[12] = '{4'b0110, {64'h0, 32'h3FC0_0000, 32'h0}, {64'h0, 32'h3FA0_0000, 32'h0},
                    3, 32'h3FF0_0000, 4'b0000, 0, 1, 32'h3FF0_0000, 4'b0000, 1'b0};

        rst_n = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), tbl[i].vmask, tbl[i].a_all, tbl[i].b_all,
                   tbl[i].dly, tbl[i].mprod, tbl[i].mfl, tbl[i].rdly, tbl[i].exp_g,
                   tbl[i].exp_p, tbl[i].exp_f, tbl[i].exp_to);
        last = 1;

        // stray done while IDLE must not start a response
        mprod_v = 32'hCAFE_F00D;
        stray_done = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        stray_done = 1'b0;
        @(posedge clk); #1;
        chk("stray_ctrl", {28'h0, busy_o, |rsp_valid_o, |req_ready_o, mul_start_o}, 32'h0);
        chk("stray_product", rsp_product_o, 32'h3FF0_0000);

        // randomized traffic against the round-robin reference
        for (int t = 0; t < 40; t++) begin
            vm = 4'($urandom_range(1, 15));
            for (int j = 0; j < N; j++) begin
                aa[j*32 +: 32] = $urandom;
                bb[j*32 +: 32] = $urandom;
            end
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            mp = $urandom;
            mf = 4'($urandom_range(0, 15));
            g = rr_ref(vm, last);
            ep = (dly == 0) ? 32'h7FC0_0000 : mp;
            ef = (dly == 0) ? 4'b1000 : mf;
            run_op($sformatf("rnd%0d", t), vm, aa, bb, dly, mp, mf,
                   $urandom_range(0, 3), g, ep, ef, dly == 0);
            last = g;
        end

        // reset during WAIT: set last grant to 2 first so 3 would win without reset
        aa = {4{32'h3F80_0001}};
        bb = {4{32'h4000_0003}};
        run_op("pre_rst", 4'b0100, aa, bb, 2, 32'h0BAD_0000, 4'b0000, 0,
               rr_ref(4'b0100, last), 32'h0BAD_0000, 4'b0000, 1'b0);
        mdelay = 0;
        req_valid_i = 4'b0010;
        @(posedge clk); #1;
        req_valid_i = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("wait_busy", 32'(busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 4'b1001, aa, bb, 2, 32'h4040_0000, 4'b0000, 0,
               0, 32'h4040_0000, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
